ac_motor_deadtime: RTL and testbench

Downstream of the AC motor PWM comparator. Converts the comparator's per-leg commands (out1/out2 with en1/en2) into four gate drives for two half-bridge legs.
- Inserts a programmable dead time on every high/low changeover.
- Never asserts both gates of one leg together.
- Forces gates off on disable.
- Output feeds the FPGA pins that drive the bridge driver ICs.

---
 rtl/ac_motor_pkg.sv | 22 ++
 rtl/ac_motor_deadtime_leg.sv | 119 +++++++++++
 rtl/ac_motor_deadtime.sv | 96 +++++++++
 tb/tb_ac_motor_deadtime.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ac_motor_pkg.sv
//------------------------------------------------------------------------------
// Module  : ac_motor_pkg
// Brief   : Shared constants and leg state encoding for the dead-time block.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ac_motor_pkg;

    localparam int c_DT_W_DEFAULT = 8;
    localparam int c_DT_MIN       = 1;

    typedef logic [1:0] leg_state_t;

    localparam leg_state_t c_ST_IDLE = 2'd0;
    localparam leg_state_t c_ST_DEAD = 2'd1;
    localparam leg_state_t c_ST_HIGH = 2'd2;
    localparam leg_state_t c_ST_LOW  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/ac_motor_deadtime_leg.sv
//------------------------------------------------------------------------------
// Module  : ac_motor_deadtime_leg
// Brief   : One half-bridge leg: IDLE/DEAD/HIGH/LOW FSM with dead-time counter.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ac_motor_deadtime_leg
    import ac_motor_pkg::*;
#(
    parameter int DT_W   = c_DT_W_DEFAULT,
    parameter int DT_MIN = c_DT_MIN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_leg_en,
    input  logic            i_cmd,
    input  logic [DT_W-1:0] i_dead_time,
    output logic            o_gate_h,
    output logic            o_gate_l
);

    localparam logic [DT_W-1:0] c_DT_MIN_V = DT_W'(DT_MIN);

    leg_state_t      r_state;
    leg_state_t      w_state_nxt;
    logic [DT_W-1:0] r_cnt;
    logic [DT_W-1:0] w_cnt_nxt;
    logic            r_target;
    logic            w_target_nxt;
    logic            r_gate_h;
    logic            r_gate_l;
    logic            w_gate_h_nxt;
    logic            w_gate_l_nxt;
    logic [DT_W-1:0] w_eff_dt;

    assign w_eff_dt = (i_dead_time < c_DT_MIN_V) ? c_DT_MIN_V : i_dead_time;

    // Gates are registered decodes of the next state so they change on the
    // same edge as the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_target <= 1'b0;
            r_gate_h <= 1'b0;
            r_gate_l <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_target <= w_target_nxt;
            r_gate_h <= w_gate_h_nxt;
            r_gate_l <= w_gate_l_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_target_nxt = r_target;
        case (r_state)
            c_ST_IDLE: begin
                if (i_leg_en) begin
                    w_state_nxt  = c_ST_DEAD;
                    w_cnt_nxt    = w_eff_dt;
                    w_target_nxt = i_cmd;
                end
            end
            c_ST_DEAD: begin
                if (!i_leg_en) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    // Target tracks the command, but the counter is never
                    // reloaded, so a glitch cannot shorten the dead time.
                    w_target_nxt = i_cmd;
                    if (r_cnt == '0) begin
                        w_state_nxt = r_target ? c_ST_HIGH : c_ST_LOW;
                    end else begin
                        w_cnt_nxt = r_cnt - DT_W'(1);
                    end
                end
            end
            c_ST_HIGH: begin
                if (!i_leg_en) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (!i_cmd) begin
                    w_state_nxt  = c_ST_DEAD;
                    w_cnt_nxt    = w_eff_dt;
                    w_target_nxt = 1'b0;
                end
            end
            c_ST_LOW: begin
                if (!i_leg_en) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (i_cmd) begin
                    w_state_nxt  = c_ST_DEAD;
                    w_cnt_nxt    = w_eff_dt;
                    w_target_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_gate_h_nxt = (w_state_nxt == c_ST_HIGH);
        w_gate_l_nxt = (w_state_nxt == c_ST_LOW);
    end

    assign o_gate_h = r_gate_h;
    assign o_gate_l = r_gate_l;

endmodule

`default_nettype wire

// File: rtl/ac_motor_deadtime.sv
//------------------------------------------------------------------------------
// Module  : ac_motor_deadtime
// Brief   : Two-leg dead-time inserter; optional fault latch via macro
//           AC_MOTOR_DEADTIME_FAULT_EN.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ac_motor_deadtime
    import ac_motor_pkg::*;
#(
    parameter int DT_W   = c_DT_W_DEFAULT,
    parameter int DT_MIN = c_DT_MIN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [DT_W-1:0] dead_time,
    input  logic            out1,
    input  logic            out2,
    input  logic            en1,
    input  logic            en2,
    input  logic            fault_in,
    input  logic            fault_clr,
    output logic            gate_h1,
    output logic            gate_l1,
    output logic            gate_h2,
    output logic            gate_l2,
    output logic            fault
);

    logic       w_fault_block;
    logic [1:0] w_cmd;
    logic [1:0] w_leg_en;
    logic [1:0] w_gate_h;
    logic [1:0] w_gate_l;

`ifdef AC_MOTOR_DEADTIME_FAULT_EN
    logic r_fault_meta;
    logic r_fault_sync;
    logic r_fault;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fault_meta <= 1'b0;
            r_fault_sync <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_fault_meta <= fault_in;
            r_fault_sync <= r_fault_meta;
            if (r_fault_sync) begin
                r_fault <= 1'b1;
            end else if (fault_clr) begin
                r_fault <= 1'b0;
            end
        end
    end

    // Blocking on the synchronized flag as well gives gates-off on the same
    // edge the latch sets, keeping the pin-to-gate latency at three edges.
    assign w_fault_block = r_fault | r_fault_sync;
    assign fault         = r_fault;
`else
    logic w_unused_fault;

    assign w_unused_fault = fault_in ^ fault_clr;
    assign w_fault_block  = 1'b0;
    assign fault          = 1'b0;
`endif

    assign w_cmd    = {out2, out1};
    assign w_leg_en = {en2, en1} & {2{enable & ~w_fault_block}};

    for (genvar i = 0; i < 2; i++) begin : g_leg
        ac_motor_deadtime_leg #(
            .DT_W   (DT_W),
            .DT_MIN (DT_MIN)
        ) u_leg (
            .clk         (clk),
            .rst         (reset),
            .i_leg_en    (w_leg_en[i]),
            .i_cmd       (w_cmd[i]),
            .i_dead_time (dead_time),
            .o_gate_h    (w_gate_h[i]),
            .o_gate_l    (w_gate_l[i])
        );
    end

    assign gate_h1 = w_gate_h[0];
    assign gate_l1 = w_gate_l[0];
    assign gate_h2 = w_gate_h[1];
    assign gate_l2 = w_gate_l[1];

endmodule

`default_nettype wire

// File: tb/tb_ac_motor_deadtime.sv
//------------------------------------------------------------------------------
// Module  : tb_ac_motor_deadtime
// Brief   : Directed self-checking bench for ac_motor_deadtime.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ac_motor_deadtime;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] dead_time;
    logic       out1;
    logic       out2;
    logic       en1;
    logic       en2;
    logic       fault_in;
    logic       fault_clr;
    logic       gate_h1;
    logic       gate_l1;
    logic       gate_h2;
    logic       gate_l2;
    logic       fault;

    int errors   = 0;
    int checks   = 0;
    int overlaps = 0;

    ac_motor_deadtime #(
        .DT_W   (8),
        .DT_MIN (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .dead_time (dead_time),
        .out1      (out1),
        .out2      (out2),
        .en1       (en1),
        .en2       (en2),
        .fault_in  (fault_in),
        .fault_clr (fault_clr),
        .gate_h1   (gate_h1),
        .gate_l1   (gate_l1),
        .gate_h2   (gate_h2),
        .gate_l2   (gate_l2),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ((gate_h1 & gate_l1) | (gate_h2 & gate_l2)) begin
            overlaps++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (gate_h1 !== 1'b0) begin errors++; $display("FAIL reset_h1 got=%b exp=0", gate_h1); end
        checks++; if (gate_l1 !== 1'b0) begin errors++; $display("FAIL reset_l1 got=%b exp=0", gate_l1); end
        checks++; if (gate_h2 !== 1'b0) begin errors++; $display("FAIL reset_h2 got=%b exp=0", gate_h2); end
        checks++; if (gate_l2 !== 1'b0) begin errors++; $display("FAIL reset_l2 got=%b exp=0", gate_l2); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", fault); end
        reset = 1'b0;
    endtask

    task automatic test_startup();
        enable = 1'b1; en1 = 1'b1; out1 = 1'b1; dead_time = 8'd5;
        for (int k = 0; k <= 6; k++) begin
            tick();
            checks++; if (gate_h1 !== (k == 6)) begin errors++; $display("FAIL startup_h1 edge=%0d got=%b exp=%b", k, gate_h1, (k == 6)); end
            checks++; if (gate_l1 !== 1'b0) begin errors++; $display("FAIL startup_l1 edge=%0d got=%b exp=0", k, gate_l1); end
        end
    endtask

    task automatic test_changeover();
        out1 = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            tick();
            checks++; if (gate_h1 !== 1'b0) begin errors++; $display("FAIL chg_h1 edge=%0d got=%b exp=0", k, gate_h1); end
            checks++; if (gate_l1 !== (k == 6)) begin errors++; $display("FAIL chg_l1 edge=%0d got=%b exp=%b", k, gate_l1, (k == 6)); end
        end
    endtask

    task automatic test_min_dead();
        dead_time = 8'd0;
        out1 = 1'b1;
        for (int k = 0; k <= 2; k++) begin
            tick();
            checks++; if (gate_l1 !== 1'b0) begin errors++; $display("FAIL mind_l1 edge=%0d got=%b exp=0", k, gate_l1); end
            checks++; if (gate_h1 !== (k == 2)) begin errors++; $display("FAIL mind_h1 edge=%0d got=%b exp=%b", k, gate_h1, (k == 2)); end
        end
        out1 = 1'b0;
        for (int k = 0; k <= 2; k++) begin
            tick();
            checks++; if (gate_h1 !== 1'b0) begin errors++; $display("FAIL mind2_h1 edge=%0d got=%b exp=0", k, gate_h1); end
            checks++; if (gate_l1 !== (k == 2)) begin errors++; $display("FAIL mind2_l1 edge=%0d got=%b exp=%b", k, gate_l1, (k == 2)); end
        end
        dead_time = 8'd5;
    endtask

    // Command glitches low during DEAD and dead_time changes mid-DEAD:
    // neither may move the rising edge of gate_h1 away from edge 6.
    task automatic test_glitch();
        out1 = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            tick();
            checks++; if (gate_h1 !== (k == 6)) begin errors++; $display("FAIL glitch_h1 edge=%0d got=%b exp=%b", k, gate_h1, (k == 6)); end
            checks++; if (gate_l1 !== 1'b0) begin errors++; $display("FAIL glitch_l1 edge=%0d got=%b exp=0", k, gate_l1); end
            if (k == 0) begin out1 = 1'b0; dead_time = 8'd20; end
            if (k == 2) out1 = 1'b1;
        end
        dead_time = 8'd3;
    endtask

    task automatic test_disable();
        en2 = 1'b1; out2 = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            tick();
            checks++; if (gate_l2 !== (k == 4)) begin errors++; $display("FAIL leg2_l2 edge=%0d got=%b exp=%b", k, gate_l2, (k == 4)); end
            checks++; if (gate_h2 !== 1'b0) begin errors++; $display("FAIL leg2_h2 edge=%0d got=%b exp=0", k, gate_h2); end
        end
        checks++; if (gate_h1 !== 1'b1) begin errors++; $display("FAIL leg1_hold got=%b exp=1", gate_h1); end
        enable = 1'b0;
        tick();
        checks++; if ({gate_h1, gate_l1, gate_h2, gate_l2} !== 4'b0000) begin errors++; $display("FAIL disable_gates got=%b exp=0000", {gate_h1, gate_l1, gate_h2, gate_l2}); end
        enable = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            tick();
            checks++; if (gate_h1 !== (k == 4)) begin errors++; $display("FAIL reen_h1 edge=%0d got=%b exp=%b", k, gate_h1, (k == 4)); end
            checks++; if (gate_l2 !== (k == 4)) begin errors++; $display("FAIL reen_l2 edge=%0d got=%b exp=%b", k, gate_l2, (k == 4)); end
        end
    endtask

    task automatic test_reset_mid_dead();
        out1 = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({gate_h1, gate_l1, gate_h2, gate_l2} !== 4'b0000) begin errors++; $display("FAIL async_reset got=%b exp=0000", {gate_h1, gate_l1, gate_h2, gate_l2}); end
        tick();
        reset = 1'b0;
        out1 = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            tick();
            checks++; if (gate_h1 !== (k == 4)) begin errors++; $display("FAIL rst_restart_h1 edge=%0d got=%b exp=%b", k, gate_h1, (k == 4)); end
        end
    endtask

`ifdef AC_MOTOR_DEADTIME_FAULT_EN
    task automatic test_fault();
        fault_in = 1'b1;
        for (int k = 0; k <= 2; k++) begin
            tick();
            checks++; if (fault !== (k == 2)) begin errors++; $display("FAIL fault_set edge=%0d got=%b exp=%b", k, fault, (k == 2)); end
            checks++; if (gate_h1 !== (k < 2)) begin errors++; $display("FAIL fault_h1 edge=%0d got=%b exp=%b", k, gate_h1, (k < 2)); end
            checks++; if (gate_l2 !== (k < 2)) begin errors++; $display("FAIL fault_l2 edge=%0d got=%b exp=%b", k, gate_l2, (k < 2)); end
        end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_clr_ignored got=%b exp=1", fault); end
        fault_in = 1'b0;
        tick(); tick(); tick();
        checks++; if (gate_h1 !== 1'b0) begin errors++; $display("FAIL fault_hold_h1 got=%b exp=0", gate_h1); end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_clear got=%b exp=0", fault); end
        for (int k = 0; k <= 4; k++) begin
            tick();
            checks++; if (gate_h1 !== (k == 4)) begin errors++; $display("FAIL fault_restart_h1 edge=%0d got=%b exp=%b", k, gate_h1, (k == 4)); end
        end
    endtask
`else
    task automatic test_fault();
        fault_in = 1'b1; fault_clr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_tied edge=%0d got=%b exp=0", k, fault); end
            checks++; if (gate_h1 !== 1'b1) begin errors++; $display("FAIL fault_ignored_h1 edge=%0d got=%b exp=1", k, gate_h1); end
        end
        fault_in = 1'b0; fault_clr = 1'b0;
    endtask
`endif

    // Comparator-like stream: triangle against a slowly varying reference,
    // with enable toggled and reset pulsed asynchronously mid-run.
    task automatic test_stream();
        int tri_v;
        int dir;
        int ref1;
        int h1_seen;
        int l1_seen;
        int h2_seen;
        int l2_seen;
        tri_v = 0; dir = 1; h1_seen = 0; l1_seen = 0; h2_seen = 0; l2_seen = 0;
        dead_time = 8'd2;
        for (int c = 0; c < 20000; c++) begin
            tri_v = tri_v + dir;
            if (tri_v >= 40) dir = -1;
            if (tri_v <= 0) dir = 1;
            ref1 = 20 + ((c / 200) % 2 == 0 ? ((c / 10) % 20) : -((c / 10) % 20));
            out1 = (ref1 > tri_v);
            out2 = (ref1 < tri_v);
            if (c == 5000) enable = 1'b0;
            if (c == 5050) enable = 1'b1;
            if (c == 9000) begin
                #2;
                reset = 1'b1;
                #1;
                checks++; if ({gate_h1, gate_l1, gate_h2, gate_l2} !== 4'b0000) begin errors++; $display("FAIL stream_reset got=%b exp=0000", {gate_h1, gate_l1, gate_h2, gate_l2}); end
            end
            if (c == 9003) reset = 1'b0;
            tick();
            if (gate_h1) h1_seen++;
            if (gate_l1) l1_seen++;
            if (gate_h2) h2_seen++;
            if (gate_l2) l2_seen++;
        end
        checks++; if (h1_seen == 0) begin errors++; $display("FAIL stream_h1_active got=%0d exp=>0", h1_seen); end
        checks++; if (l1_seen == 0) begin errors++; $display("FAIL stream_l1_active got=%0d exp=>0", l1_seen); end
        checks++; if (h2_seen == 0) begin errors++; $display("FAIL stream_h2_active got=%0d exp=>0", h2_seen); end
        checks++; if (l2_seen == 0) begin errors++; $display("FAIL stream_l2_active got=%0d exp=>0", l2_seen); end
        checks++; if (overlaps != 0) begin errors++; $display("FAIL shoot_through got=%0d exp=0", overlaps); end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; dead_time = 8'd5;
        out1 = 1'b0; out2 = 1'b0; en1 = 1'b0; en2 = 1'b0;
        fault_in = 1'b0; fault_clr = 1'b0;
        test_reset();
        test_startup();
        test_changeover();
        test_min_dead();
        test_glitch();
        test_disable();
        test_reset_mid_dead();
        test_fault();
        test_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
